// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central sequencer for a 5-stage MIPS pipeline. It drives the PC and IF/ID
// write enables, the ID/EX bubble and IF/ID flush controls, and a whole-pipe
// hold while data memory is busy. Start-up is gated on `start`, a decoded
// halt drains the pipe, and saturating performance counters track load-use
// stalls, taken-branch flushes and memory-wait cycles.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   defined   -> stall_cnt / flush_cnt / memwait_cnt are real counters
//   undefined -> no counter flops, the three outputs are tied to zero
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   start         level; leaves IDLE when sampled high
//   id_rs/id_rt   source registers of the instruction in ID
//   id_uses_rt    ID instruction reads rt
//   idex_memread  instruction in EX is a load
//   idex_rt       load destination in EX
//   branch_taken  branch/jump resolved taken in ID
//   mem_busy      data memory not ready this cycle
//   halt          halt decoded in ID
//   pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold  pipeline controls
//   stall_cnt, flush_cnt, memwait_cnt                          perf counters
//   state_o       IDLE=0, RUN=1, MEM_WAIT=2, DRAIN=3
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              halt,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_hold,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  memwait_cnt,
    output logic [1:0]        state_o
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            load_use_s;
    logic            stall_ev_s;
    logic            flush_ev_s;
    logic            memwait_ev_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Load-use hazard; r0 as load destination never stalls.
    assign load_use_s = idex_memread
                      && (idex_rt != {REG_AW{1'b0}})
                      && ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

    assign state_o = state_q;

    // Control decode and next-state logic for the sequencer.
    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pipe_hold    = 1'b0;
        stall_ev_s   = 1'b0;
        flush_ev_s   = 1'b0;
        memwait_ev_s = 1'b0;
        state_d      = state_q;
        drain_d      = drain_q;
        case (state_q)
            ST_IDLE: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // MEM_WAIT shares the RUN decode: on its release cycle the
            // remaining RUN priorities apply unchanged.
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    pipe_hold    = 1'b1;
                    memwait_ev_s = 1'b1;
                    state_d      = ST_MEM_WAIT;
                end else if (load_use_s) begin
                    idex_bubble = 1'b1;
                    stall_ev_s  = 1'b1;
                    state_d     = ST_RUN;
                end else if (halt) begin
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                    drain_d    = DRAIN_LOAD;
                    state_d    = ST_DRAIN;
                end else if (branch_taken) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                    flush_ev_s = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_DRAIN: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                pipe_hold   = mem_busy;
                if (mem_busy) begin
                    drain_d = drain_q;
                end else if (drain_q != {DW{1'b0}}) begin
                    drain_d = drain_q - {{(DW-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_d     = ST_IDLE;
                drain_d     = {DW{1'b0}};
            end
        endcase
    end

    // State and drain-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            drain_q <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

    // Next values of the performance counters.
    always_comb begin
        stall_cnt_d   = stall_ev_s   ? sat_inc(stall_cnt_q)   : stall_cnt_q;
        flush_cnt_d   = flush_ev_s   ? sat_inc(flush_cnt_q)   : flush_cnt_q;
        memwait_cnt_d = memwait_ev_s ? sat_inc(memwait_cnt_q) : memwait_cnt_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q   <= {CNT_W{1'b0}};
            flush_cnt_q   <= {CNT_W{1'b0}};
            memwait_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign memwait_cnt = memwait_cnt_q;
`else
    // Counter events have no consumer when the counters are compiled out.
    logic unused_ev_s;
    assign unused_ev_s = ^{stall_ev_s, flush_ev_s, memwait_ev_s, sat_inc({CNT_W{1'b0}})};

    assign stall_cnt   = {CNT_W{1'b0}};
    assign flush_cnt   = {CNT_W{1'b0}};
    assign memwait_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// Directed testbench for pipeline_hazard_ctrl. The counters are built 4 bits
// wide so saturation is reachable quickly. Expected counter values are zero
// when PIPE_PERF_CNT_EN is not defined.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    id_rs, id_rt, idex_rt;
    logic          id_uses_rt, idex_memread, branch_taken, mem_busy, halt;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
    logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;
    logic [1:0]    state_o;

    int tests = 0;
    int fails = 0;

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(CW), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .halt(halt),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic int cexp(input int v);
        return v * PERF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        start = 1'b0; id_rs = 5'd0; id_rt = 5'd0; idex_rt = 5'd0;
        id_uses_rt = 1'b0; idex_memread = 1'b0; branch_taken = 1'b0;
        mem_busy = 1'b0; halt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hazard_rs8();
        idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    endtask

    initial begin
        rst = 1'b0;
        clr();
        #2;
        chk("rst_state", state_o, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_ifid_write", ifid_write, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_bubble", idex_bubble, 1);
        chk("rst_hold", pipe_hold, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        #10;
        rst = 1'b1;

        // Start for one cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("start_state", state_o, 1);
        chk("run_pc_write", pc_write, 1);
        chk("run_ifid_write", ifid_write, 1);
        chk("run_flush_cnt", flush_cnt, 0);
        chk("run_memwait_cnt", memwait_cnt, 0);

        // Load-use hazard through rs.
        hazard_rs8();
        #1;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        chk("lu_bubble", idex_bubble, 1);
        tick();
        clr();
        #1;
        chk("lu_stall_cnt", stall_cnt, cexp(1));

        // Load to r0 never stalls.
        idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("r0_pc_write", pc_write, 1);
        chk("r0_bubble", idex_bubble, 0);
        tick();
        clr();
        #1;
        chk("r0_stall_cnt", stall_cnt, cexp(1));

        // Hazard through rt only when rt is used.
        idex_memread = 1'b1; idex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3;
        id_uses_rt = 1'b0;
        #1;
        chk("rt_unused_bubble", idex_bubble, 0);
        id_uses_rt = 1'b1;
        #1;
        chk("rt_used_bubble", idex_bubble, 1);
        tick();
        clr();
        #1;
        chk("rt_stall_cnt", stall_cnt, cexp(2));

        // Three separate taken branches.
        for (int i = 0; i < 3; i++) begin
            branch_taken = 1'b1;
            #1;
            chk("br_flush", ifid_flush, 1);
            chk("br_pc_write", pc_write, 1);
            tick();
            clr();
            tick();
        end
        chk("br_flush_cnt", flush_cnt, cexp(3));

        // Branch coincident with load-use: stall wins, no flush.
        hazard_rs8();
        branch_taken = 1'b1;
        #1;
        chk("brlu_flush", ifid_flush, 0);
        chk("brlu_bubble", idex_bubble, 1);
        tick();
        clr();
        #1;
        chk("brlu_flush_cnt", flush_cnt, cexp(3));
        chk("brlu_stall_cnt", stall_cnt, cexp(3));

        // mem_busy for four cycles.
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mw_hold", pipe_hold, 1);
            chk("mw_pc_write", pc_write, 0);
            tick();
            chk("mw_state", state_o, 2);
        end
        chk("mw_memwait_cnt", memwait_cnt, cexp(4));

        // Release cycle with a load-use hazard still stalls.
        mem_busy = 1'b0;
        hazard_rs8();
        #1;
        chk("rel_hold", pipe_hold, 0);
        chk("rel_bubble", idex_bubble, 1);
        chk("rel_pc_write", pc_write, 0);
        tick();
        clr();
        #1;
        chk("rel_state", state_o, 1);
        chk("rel_stall_cnt", stall_cnt, cexp(4));

        // halt with branch: drain, no flush count.
        halt = 1'b1;
        branch_taken = 1'b1;
        #1;
        chk("halt_pc_write", pc_write, 0);
        chk("halt_flush", ifid_flush, 1);
        tick();
        clr();
        #1;
        chk("halt_state", state_o, 3);
        chk("halt_flush_cnt", flush_cnt, cexp(3));
        chk("drain_pc_write", pc_write, 0);
        chk("drain_bubble", idex_bubble, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("drain_state", state_o, 3);
        end
        tick();
        chk("drain_exit_state", state_o, 0);

        // Restart and saturate stall_cnt (4 bits).
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_state", state_o, 1);
        for (int i = 0; i < 11; i++) begin
            hazard_rs8();
            tick();
        end
        chk("sat_stall_cnt", stall_cnt, cexp(15));
        tick();
        clr();
        #1;
        chk("sat_hold_stall_cnt", stall_cnt, cexp(15));

        // Asynchronous reset mid-RUN.
        #1;
        rst = 1'b0;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_flush_cnt", flush_cnt, 0);
        chk("arst_memwait_cnt", memwait_cnt, 0);
        chk("arst_flush", ifid_flush, 1);
        #3;
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
